user_write_arbiter: RTL and testbench
=====================================

Name: user_write_arbiter

Overview:
Upstream stage of the user-locked register. Takes write requests from four user ports (user IDs 0-3) and picks one per slot by round-robin. Drives one registered (usr_id, data) write beat per grant into the downstream register's usr_id/data_in inputs. Between beats it drives a non-privileged idle ID, so the downstream register never sees a spurious privileged write.

Parameters:
PRIV_ID, 2'h2, user ID the downstream register accepts; used by the optional filter.
IDLE_ID, 2'h0, ID driven when no beat is active; must differ from PRIV_ID.
HOLD_CYCLES, 1, dead cycles after each beat before the next arbitration (0-15).

Ports:
clk  input  1  single clock; all logic on posedge.
rst_n  input  1  synchronous reset, active-high (reset when rst_n==1 at posedge clk).
req_valid  input  4  per-user request; bit i = user ID i.
req_data  input  32  packed payloads; bits [8i+7:8i] belong to user i.
req_ready  output  4  one-hot grant/accept; handshake for user i = req_valid[i] & req_ready[i].
wr_usr_id  output  2  to downstream usr_id.
wr_data  output  8  to downstream data_in.
wr_valid  output  1  high for exactly the beat cycle.
busy  output  1  high in any state other than IDLE.
deny_cnt  output  8  filtered-request count (optional feature).

Behaviour:
- Reset: state=IDLE, rr_ptr=0, hold counter=0, wr_valid=0, wr_usr_id=IDLE_ID, wr_data=0, busy=0, deny_cnt=0, req_ready=0.
- Reset has priority over every other event. Reset during ISSUE or HOLD aborts: outputs return to reset values at that edge and no further beat is issued.
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod 4. All zero if no request.
  - On the handshake edge: wr_usr_id<=i, wr_data<=req_data[8i+7:8i], wr_valid<=1, rr_ptr<=(i+1) mod 4, state<=ISSUE.
- ISSUE:
  - Lasts exactly one cycle; req_ready=0.
  - Next edge: wr_valid<=0, wr_usr_id<=IDLE_ID, wr_data<=0.
  - State goes to HOLD with counter=HOLD_CYCLES-1 if HOLD_CYCLES>0, else to IDLE.
- HOLD:
  - req_ready=0. Counter decrements each edge; the edge where counter==0 moves to IDLE.
- Latency: grant at edge N; beat visible in cycle N..N+1; downstream samples it at edge N+1.
- Throughput: one beat per 2+HOLD_CYCLES cycles.
- Fairness: a continuously requesting user waits at most 3 other grants.
- Requesters hold req_data stable while req_valid is high. Dropping req_valid before a grant is legal and loses nothing.
- Simultaneous requests: only one is granted per slot. The others see req_ready=0 and keep their requests pending.
- busy = (state != IDLE).
- Outputs wr_* are registered only; no combinational path from req_* to wr_*.

Optional Feature:
USER_ARB_PRIV_FILTER_EN
- Defined:
  - A handshake from a user with i != PRIV_ID is still accepted (req_ready pulses), but not forwarded.
  - wr_valid stays 0 and wr_usr_id stays IDLE_ID.
  - deny_cnt increments, saturating at 8'hFF.
  - rr_ptr still advances; state stays IDLE, so the next grant can follow in the next cycle.
  - Only PRIV_ID requests produce ISSUE beats.
- Undefined: deny_cnt tied to 0; every granted request is forwarded.

Test Plan:
- Reset with rst_n=1 for 2 cycles, then release: wr_valid=0, wr_usr_id=2'h0, wr_data=0, req_ready=0, busy=0.
- req_valid=4'b0100, user 2 data 8'hA5: req_ready=4'b0100 in that cycle; next cycle wr_valid=1, wr_usr_id=2, wr_data=8'hA5; then one HOLD cycle (busy=1); idle again 3 cycles after grant.
- All four users request continuously, HOLD_CYCLES=1: grant order 0,1,2,3,0 with grants 3 cycles apart; wr_usr_id returns to 0 between beats.
- rst_n=1 asserted during the ISSUE cycle of user 2 (data 8'h3C): at that edge wr_valid=0, wr_usr_id=IDLE_ID, state IDLE; no second beat after release.
- With USER_ARB_PRIV_FILTER_EN: users 1 and 2 request (data 8'h11, 8'h22) from rr_ptr=0. User 1 is accepted with wr_valid staying 0 and deny_cnt=1. Next cycle user 2 is granted; beat wr_usr_id=2, wr_data=8'h22.
- With USER_ARB_PRIV_FILTER_EN: user 0 requests continuously for 300 grants; deny_cnt saturates at 8'hFF and wr_valid never asserts.

Source files
------------

// File: rtl/user_write_arbiter_if.sv
// Request/beat bundle between the four user ports, the write arbiter and the
// downstream user-locked register.
interface user_write_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  wr_usr_id;
    logic [7:0]  wr_data;
    logic        wr_valid;

    modport slave (
        input  req_valid, req_data,
        output req_ready, wr_usr_id, wr_data, wr_valid
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, wr_usr_id, wr_data, wr_valid
    );
endinterface

// File: rtl/user_write_arbiter.sv
// Round-robin arbiter feeding one registered (usr_id, data) beat per grant to the
// user-locked register. Optional macro USER_ARB_PRIV_FILTER_EN drops non-PRIV_ID grants.
module user_write_arbiter #(
    parameter logic [1:0]  PRIV_ID     = 2'h2,
    parameter logic [1:0]  IDLE_ID     = 2'h0,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    user_write_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [7:0]           deny_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_e;

    if (PRIV_ID == IDLE_ID) begin : g_bad_cfg
        $error("user_write_arbiter: IDLE_ID must differ from PRIV_ID");
    end

    state_e     state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] hold_q, hold_d;
    logic       wr_valid_q, wr_valid_d;
    logic [1:0] wr_usr_id_q, wr_usr_id_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic       fwd;

    // First requester at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE && gnt_found) ? (4'b0001 << gnt_idx) : '0;

`ifdef USER_ARB_PRIV_FILTER_EN
    logic [7:0] deny_q, deny_d;
    assign fwd      = (gnt_idx == PRIV_ID);
    assign deny_cnt = deny_q;
`else
    assign fwd      = 1'b1;
    assign deny_cnt = '0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        wr_valid_d  = wr_valid_q;
        wr_usr_id_d = wr_usr_id_q;
        wr_data_d   = wr_data_q;
`ifdef USER_ARB_PRIV_FILTER_EN
        deny_d      = deny_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    rr_ptr_d = gnt_idx + 2'd1;
                    if (fwd) begin
                        wr_valid_d  = 1'b1;
                        wr_usr_id_d = gnt_idx;
                        wr_data_d   = bus.req_data[{gnt_idx, 3'b000} +: 8];
                        state_d     = S_ISSUE;
                    end
`ifdef USER_ARB_PRIV_FILTER_EN
                    else if (deny_q != 8'hFF) begin
                        deny_d = deny_q + 8'd1;
                    end
`endif
                end
            end
            S_ISSUE: begin
                wr_valid_d  = 1'b0;
                wr_usr_id_d = IDLE_ID;
                wr_data_d   = '0;
                if (HOLD_CYCLES > 0) begin
                    hold_d  = 4'(HOLD_CYCLES - 1);
                    state_d = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rst_n is active-high despite its name; kept for drop-in compatibility.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            hold_q      <= '0;
            wr_valid_q  <= 1'b0;
            wr_usr_id_q <= IDLE_ID;
            wr_data_q   <= '0;
`ifdef USER_ARB_PRIV_FILTER_EN
            deny_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            wr_valid_q  <= wr_valid_d;
            wr_usr_id_q <= wr_usr_id_d;
            wr_data_q   <= wr_data_d;
`ifdef USER_ARB_PRIV_FILTER_EN
            deny_q      <= deny_d;
`endif
        end
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_usr_id = wr_usr_id_q;
    assign bus.wr_data   = wr_data_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_user_write_arbiter.sv
// Self-checking bench for user_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a cooldown-based reference model.
module tb_user_write_arbiter;

    localparam logic [1:0] PRIV = 2'h2;
    localparam logic [1:0] IDLE = 2'h0;
    localparam int         HOLD = 1;
`ifdef USER_ARB_PRIV_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] deny_cnt;

    user_write_arbiter_if bus();

    user_write_arbiter #(
        .PRIV_ID     (PRIV),
        .IDLE_ID     (IDLE),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .deny_cnt (deny_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: after a forwarded grant no arbitration happens for
    // 1+HOLD cycles; the beat is visible for exactly the first of those cycles.
    int         m_rr;
    int         m_cool;
    logic       m_wv;
    logic [1:0] m_id;
    logic [7:0] m_data;
    logic [7:0] m_deny;
    int         m_g;

    function automatic logic [3:0] model_ready();
        if (m_cool != 0) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (bus.req_valid[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            m_rr = 0; m_cool = 0; m_wv = 1'b0; m_id = IDLE; m_data = '0; m_deny = '0;
        end else begin
            m_g = -1;
            for (int k = 0; k < 4; k++)
                if (model_ready() == (4'b0001 << k)) m_g = k;
            m_wv = 1'b0; m_id = IDLE; m_data = '0;
            if (m_cool > 0) begin
                m_cool = m_cool - 1;
            end else if (m_g >= 0) begin
                m_rr = (m_g + 1) % 4;
                if (!FILTER || m_g == int'(PRIV)) begin
                    m_wv   = 1'b1;
                    m_id   = 2'(m_g);
                    m_data = bus.req_data[8*m_g +: 8];
                    m_cool = 1 + HOLD;
                end else if (m_deny != 8'hFF) begin
                    m_deny = m_deny + 8'd1;
                end
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(model_ready()));
            chk("wr_valid",  32'(bus.wr_valid),  32'(m_wv));
            chk("wr_usr_id", 32'(bus.wr_usr_id), 32'(m_id));
            chk("wr_data",   32'(bus.wr_data),   32'(m_data));
            chk("busy",      32'(busy),          32'(m_cool > 0));
            chk("deny_cnt",  32'(deny_cnt),      32'(FILTER ? m_deny : 8'h00));
        end
    end

    // Grant log for the ordering scenario.
    bit log_en = 1'b0;
    int cyc = 0;
    int gq_id[$];
    int gq_t[$];
    always @(posedge clk) begin
        cyc++;
        if (log_en && !rst_n && |(bus.req_valid & bus.req_ready)) begin
            for (int k = 0; k < 4; k++)
                if (bus.req_ready[k]) begin
                    gq_id.push_back(k);
                    gq_t.push_back(cyc);
                end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] hs;
    int         wv_seen;

    initial begin
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_wr_valid", 32'(bus.wr_valid), 0);
        chk("rst_wr_usr_id", 32'(bus.wr_usr_id), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_busy", 32'(busy), 0);

        // Single beat from user 2
        to_drive();
        bus.req_valid = 4'b0100;
        bus.req_data[23:16] = 8'hA5;
        @(negedge clk);
        chk("u2_ready", 32'(bus.req_ready), 32'h4);
        to_drive();
        bus.req_valid = '0;
        @(negedge clk);
        chk("u2_beat_valid", 32'(bus.wr_valid), 1);
        chk("u2_beat_id", 32'(bus.wr_usr_id), 2);
        chk("u2_beat_data", 32'(bus.wr_data), 32'hA5);
        @(negedge clk);
        chk("u2_hold_busy", 32'(busy), 1);
        chk("u2_hold_valid", 32'(bus.wr_valid), 0);
        chk("u2_hold_id", 32'(bus.wr_usr_id), 0);
        @(negedge clk);
        chk("u2_idle_busy", 32'(busy), 0);
        to_drive();

`ifndef USER_ARB_PRIV_FILTER_EN
        // All four users requesting continuously
        do_reset();
        bus.req_data  = 32'h44332211;
        bus.req_valid = 4'b1111;
        gq_id.delete();
        gq_t.delete();
        log_en = 1'b1;
        repeat (14) to_drive();
        log_en = 1'b0;
        bus.req_valid = '0;
        chk("rr_grant_count", 32'(gq_id.size() >= 5), 1);
        if (gq_id.size() >= 5) begin
            chk("rr_order0", 32'(gq_id[0]), 0);
            chk("rr_order1", 32'(gq_id[1]), 1);
            chk("rr_order2", 32'(gq_id[2]), 2);
            chk("rr_order3", 32'(gq_id[3]), 3);
            chk("rr_order4", 32'(gq_id[4]), 0);
            for (int k = 1; k < 5; k++)
                chk("rr_spacing", 32'(gq_t[k] - gq_t[k-1]), 3);
        end
        repeat (3) to_drive();
`endif

        // Reset during the ISSUE cycle aborts the beat
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_data[23:16] = 8'h3C;
        @(negedge clk);
        chk("abort_ready", 32'(bus.req_ready), 32'h4);
        to_drive();
        rst_n = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("abort_issue_data", 32'(bus.wr_data), 32'h3C);
        to_drive();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_wr_valid", 32'(bus.wr_valid), 0);
        chk("abort_wr_id", 32'(bus.wr_usr_id), 32'(IDLE));
        chk("abort_busy", 32'(busy), 0);
        wv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.wr_valid) wv_seen++;
        end
        chk("abort_no_beat", 32'(wv_seen), 0);
        to_drive();

`ifdef USER_ARB_PRIV_FILTER_EN
        // Non-privileged grant is swallowed, privileged one follows next cycle
        do_reset();
        bus.req_valid = 4'b0110;
        bus.req_data[15:8]  = 8'h11;
        bus.req_data[23:16] = 8'h22;
        @(negedge clk);
        chk("flt_ready1", 32'(bus.req_ready), 32'h2);
        to_drive();
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("flt_no_beat", 32'(bus.wr_valid), 0);
        chk("flt_deny1", 32'(deny_cnt), 1);
        chk("flt_ready2", 32'(bus.req_ready), 32'h4);
        to_drive();
        bus.req_valid = '0;
        @(negedge clk);
        chk("flt_beat_valid", 32'(bus.wr_valid), 1);
        chk("flt_beat_id", 32'(bus.wr_usr_id), 2);
        chk("flt_beat_data", 32'(bus.wr_data), 32'h22);
        to_drive();

        // Deny counter saturation
        do_reset();
        bus.req_valid = 4'b0001;
        wv_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.wr_valid) wv_seen++;
        end
        chk("flt_sat_deny", 32'(deny_cnt), 32'hFF);
        chk("flt_sat_no_beat", 32'(wv_seen), 0);
        to_drive();
        bus.req_valid = '0;
`endif

        // Randomized traffic; requesters keep data stable while valid
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int dens;
            dens = (n < 1000) ? 3 : ((n < 2000) ? 20 : 80);
            @(posedge clk);
            hs = bus.req_valid & bus.req_ready;
            #1;
            rst_n = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < 4; i++) begin
                if (hs[i] || !bus.req_valid[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 99) < dens);
                    bus.req_data[8*i +: 8] = 8'($urandom);
                end else if ($urandom_range(0, 49) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        bus.req_valid = '0;
        rst_n = 1'b0;
        repeat (4) to_drive();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
